// File: rtl/smux_arb.sv
// Two-requester arbiter driving a registered mux output; ownership is bounded
// by MAX_HOLD consecutive transfers whenever the other side is waiting.
module smux_arb #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t           r_state, w_next;
  logic [3:0]       r_cnt, w_cnt, w_cnt_inc;
  logic             r_last_b, w_last_b;
  logic [WIDTH-1:0] r_out, w_data;
  logic             r_valid, w_xfer;

  assign w_cnt_inc = (r_cnt >= HOLD_MAX) ? HOLD_MAX : r_cnt + 4'd1;

  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_last_b = r_last_b;
    w_xfer   = 1'b0;
    w_data   = a;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (req_a && req_b) w_next = r_last_b ? OWN_A : OWN_B;
        else if (req_a)     w_next = OWN_A;
        else if (req_b)     w_next = OWN_B;
      end
      OWN_A: begin
        w_data = a;
        if (req_a) begin
          w_xfer = 1'b1;
          w_cnt  = w_cnt_inc;
          // Hitting the limit with B waiting makes this transfer A's last.
          if (w_cnt_inc == HOLD_MAX && req_b) begin
            w_next   = OWN_B;
            w_cnt    = '0;
            w_last_b = 1'b0;
          end
        end else begin
          w_next   = req_b ? OWN_B : IDLE;
          w_cnt    = '0;
          w_last_b = 1'b0;
        end
      end
      OWN_B: begin
        w_data = b;
        if (req_b) begin
          w_xfer = 1'b1;
          w_cnt  = w_cnt_inc;
          if (w_cnt_inc == HOLD_MAX && req_a) begin
            w_next   = OWN_A;
            w_cnt    = '0;
            w_last_b = 1'b1;
          end
        end else begin
          w_next   = req_a ? OWN_A : IDLE;
          w_cnt    = '0;
          w_last_b = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        w_cnt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_b <= 1'b1;
      r_out    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_last_b <= w_last_b;
      r_valid  <= w_xfer;
      if (w_xfer) r_out <= w_data;
    end
  end

  assign gnt_a     = (r_state == OWN_A);
  assign gnt_b     = (r_state == OWN_B);
  assign sel       = (r_state == OWN_A);
  assign out       = r_out;
  assign out_valid = r_valid;

endmodule

// File: doc/smux_arb.md
SMUX_ARB -- requirements
Module: smux_arb

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the data width of a, b and out.
REQ-002 Parameter MAX_HOLD, default 4, legal range 1..15, SHALL set the maximum number of consecutive transfers one owner may make while the other requester is waiting.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 req_a  input  1  SHALL be requester A's request; a transfer is pending while high.
REQ-006 req_b  input  1  SHALL be requester B's request.
REQ-007 a  input  WIDTH  SHALL be requester A's data.
REQ-008 b  input  WIDTH  SHALL be requester B's data.
REQ-009 gnt_a  output  1  SHALL indicate that A owns the output path.
REQ-010 gnt_b  output  1  SHALL indicate that B owns the output path.
REQ-011 sel  output  1  SHALL be the mux select: 1 when A owns the path, 0 otherwise.
REQ-012 out  output  WIDTH  SHALL be the registered output data.
REQ-013 out_valid  output  1  SHALL indicate that out was loaded on the preceding edge.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, OWN_A and OWN_B.
REQ-015 gnt_a, gnt_b and sel SHALL be pure decodes of the registered state: gnt_a=sel=(state==OWN_A) and gnt_b=(state==OWN_B); gnt_a and gnt_b are never both 1.
REQ-016 In IDLE, on an edge with only req_a high, the FSM SHALL go to OWN_A; with only req_b high, to OWN_B; with neither high, it stays in IDLE.
REQ-017 In IDLE with both requests high, the FSM SHALL go to the owner not recorded in the 1-bit last-served pointer: last=B gives OWN_A, last=A gives OWN_B.
REQ-018 A transfer occurs on an edge where the owner's request is high; out SHALL load the owner's data and out_valid SHALL be 1 for the following cycle.
REQ-019 On every other edge, including all edges in IDLE, out SHALL hold its value and out_valid SHALL be 0.
REQ-020 Latency: a request rising while idle produces the grant 1 cycle later and out_valid 2 cycles later.
REQ-021 A hold counter, at least 4 bits wide, SHALL increment on each transfer, saturate at MAX_HOLD, and clear to 0 on every ownership change or entry to IDLE.
REQ-022 On an edge where the owner's request is low, ownership SHALL end: the FSM goes to the other owner if the other request is high, otherwise to IDLE; last-served is updated to the departing owner.
REQ-023 A transfer that brings the counter to MAX_HOLD while the other request is high SHALL be the owner's last: the FSM switches to the other owner on that same edge and last-served is updated.
REQ-024 If the other request is low, the owner SHALL retain ownership indefinitely, with the counter saturated.
REQ-025 If the other request rises later, the switch SHALL occur after the owner's next transfer.
REQ-026 With MAX_HOLD=1 and both requests held high, ownership SHALL alternate after every transfer: A, B, A, B, and so on.
REQ-027 The state, counter, pointer and out registers SHALL never be affected by changes in the data inputs between edges.

Reset
REQ-028 While rst is high, the block SHALL force: state=IDLE, gnt_a=0, gnt_b=0, sel=0, out=0, out_valid=0, counter=0 and last-served=B.
REQ-029 Reset assertion SHALL take effect immediately, without a clock edge.
REQ-030 Reset asserted mid-ownership SHALL abandon any pending transfer; no out_valid pulse follows the reset.
REQ-031 After rst deasserts, the first edge SHALL be evaluated from IDLE, and A wins a tie.

Verification (WIDTH=1, MAX_HOLD=4)
REQ-032 Release reset, hold req_a=1 and a=1 -> gnt_a=1 and sel=1 after 1 cycle, then out=1 with out_valid=1 after 2 cycles, with out_valid staying 1 each cycle.
REQ-033 Assert req_a=1 and req_b=1 together from IDLE after reset -> A is granted first, makes 4 transfers, then gnt_b=1; B makes 4 transfers, then A again.
REQ-034 A owns the path, req_a drops while req_b=1 -> gnt_b=1 on the next edge, with no IDLE cycle and no out_valid in the handover cycle.
REQ-035 A owns the path alone for 10 transfers with req_b=0, then req_b rises -> A keeps the grant for exactly 1 more transfer, then B is granted.
REQ-036 Assert rst asynchronously mid-burst, with out=1 and gnt_b=1 -> out=0, out_valid=0, gnt_b=0 and sel=0 immediately; after release with both requests high, A is granted.
REQ-037 Rerun with MAX_HOLD=1 and both requests high -> gnt_a and gnt_b alternate every cycle, and out follows a and b alternately.
